// File: rtl/alu_mdu_if.sv
// alu_mdu_if: operand/command/result bundle for alu_mdu.
//   AluOp1, AluOp2 : operands (dividend/multiplicand, divisor/multiplier)
//   AluCtrl        : 4-bit operation select
//   Start          : launch a multi-cycle multiply/divide
//   AluResult, Zero: combinational result and its zero flag
//   Busy, Done     : multi-cycle op in progress / one-cycle completion pulse
// master drives operands and commands; slave (the ALU) drives results.
interface alu_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] AluOp1;
  logic [WIDTH-1:0] AluOp2;
  logic [3:0]       AluCtrl;
  logic             Start;
  logic [WIDTH-1:0] AluResult;
  logic             Zero;
  logic             Busy;
  logic             Done;

  modport master (
    output AluOp1, AluOp2, AluCtrl, Start,
    input  AluResult, Zero, Busy, Done
  );

  modport slave (
    input  AluOp1, AluOp2, AluCtrl, Start,
    output AluResult, Zero, Busy, Done
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus an iterative multiply/divide unit with HI/LO.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : alu_mdu_if slave (operands, AluCtrl, Start in; AluResult, Zero, Busy, Done out)
// Multiply is shift-add, divide is restoring, both on operand magnitudes with the
// sign applied when the last of WIDTH steps commits into HI/LO.
// Optional feature: define ALU_MDU_DIV_EN to build the divider (DIV/DIVU). Without it,
// divide codes are not launched and no divider logic is generated.
module alu_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  alu_mdu_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] acc_q;    // product high half / partial remainder
  logic [WIDTH-1:0] wrk_q;    // multiplier bits / dividend bits becoming quotient
  logic [WIDTH-1:0] mcand_q;  // multiplicand or divisor magnitude
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             busy_q, done_q;
`ifdef ALU_MDU_DIV_EN
  logic             div_q;
  logic             neg_rem_q;
  logic [WIDTH:0]   sh_rem, diff;
`endif

  logic             is_mul, is_div, launch, div0;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] acc_n, wrk_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [WIDTH-1:0] result;

  // Launch decode
  assign is_mul = (bus.AluCtrl[3:1] == 3'b100);
`ifdef ALU_MDU_DIV_EN
  assign is_div = (bus.AluCtrl[3:1] == 3'b101);
  assign div0   = is_div && (bus.AluOp2 == '0);
`else
  assign is_div = 1'b0;
  assign div0   = 1'b0;
`endif
  assign launch = bus.Start && (is_mul || is_div) && (state_q != StRun);

  // Even codes (MULT, DIV) are signed
  assign s1   = ~bus.AluCtrl[0] & bus.AluOp1[WIDTH-1];
  assign s2   = ~bus.AluCtrl[0] & bus.AluOp2[WIDTH-1];
  assign mag1 = s1 ? -bus.AluOp1 : bus.AluOp1;
  assign mag2 = s2 ? -bus.AluOp2 : bus.AluOp2;

  // One iteration step
  always_comb begin
    add_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, mcand_q} : '0);
    acc_n   = add_sum[WIDTH:1];
    wrk_n   = {add_sum[0], wrk_q[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
    sh_rem  = {acc_q, wrk_q[WIDTH-1]};
    diff    = sh_rem - {1'b0, mcand_q};
    if (div_q) begin
      // Partial remainder stays below the divisor, so it always fits WIDTH bits
      acc_n = diff[WIDTH] ? sh_rem[WIDTH-1:0] : diff[WIDTH-1:0];
      wrk_n = {wrk_q[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end

  // Sign correction of the final step's values
  always_comb begin
    prod = {acc_n, wrk_n};
    if (neg_q) prod = -prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
    if (div_q) begin
      res_lo = neg_q ? -wrk_n : wrk_n;
      res_hi = neg_rem_q ? -acc_n : acc_n;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      wrk_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      div_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StRun: begin
          acc_q <= acc_n;
          wrk_q <= wrk_n;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= res_hi;
            lo_q    <= res_lo;
          end
        end
        default: begin  // StIdle and StDone both accept a new launch
          state_q <= StIdle;
          done_q  <= 1'b0;
          if (launch) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            neg_q   <= s1 ^ s2;
            wrk_q   <= is_div ? mag1 : mag2;
            mcand_q <= is_div ? mag2 : mag1;
`ifdef ALU_MDU_DIV_EN
            div_q     <= is_div;
            neg_rem_q <= s1;
`endif
            if (div0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              hi_q    <= bus.AluOp1;
              lo_q    <= '1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    result = '0;
    case (bus.AluCtrl)
      4'b0000: result = bus.AluOp1 & bus.AluOp2;
      4'b0001: result = bus.AluOp1 | bus.AluOp2;
      4'b0010: result = bus.AluOp1 + bus.AluOp2;
      4'b0110: result = bus.AluOp1 - bus.AluOp2;
      4'b0111: result = {{(WIDTH-1){1'b0}}, ($signed(bus.AluOp1) < $signed(bus.AluOp2))};
      4'b1100: result = hi_q;
      4'b1101: result = lo_q;
      default: result = '0;
    endcase
  end

  assign bus.AluResult = result;
  assign bus.Zero      = (result == '0);
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed plus randomized checks of alu_mdu (WIDTH=32) against an
// arithmetic reference model. Divide checks follow ALU_MDU_DIV_EN.
module tb_alu_mdu;
  localparam int W = 32;
`ifdef ALU_MDU_DIV_EN
  localparam int NMDU = 4;
`else
  localparam int NMDU = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] m_hi, m_lo;

  alu_mdu_if #(.WIDTH(W)) bus ();
  alu_mdu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] hi,
                                          input logic [W-1:0] lo);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1100: return hi;
      4'b1101: return lo;
      default: return '0;
    endcase
  endfunction

  function automatic void ref_mdu(input logic [3:0] c, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] hi,
                                  output logic [W-1:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (c)
      4'b1000: begin p = sa * sb; {hi, lo} = p; end
      4'b1001: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; end
      4'b1010, 4'b1011: begin
        if (b == 0) begin
          hi = a;
          lo = '1;
        end else begin
          if (c == 4'b1011) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
          end
          q  = sa / sb;
          r  = sa % sb;
          lo = q[W-1:0];
          hi = r[W-1:0];
        end
      end
      default: ;
    endcase
  endfunction

  task automatic comb_check(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                            input logic [W-1:0] b);
    logic [W-1:0] e;
    bus.AluCtrl = c;
    bus.AluOp1  = a;
    bus.AluOp2  = b;
    #1;
    e = ref_alu(c, a, b, m_hi, m_lo);
    check(tag, bus.AluResult, e);
    check({tag, "_zero"}, bus.Zero, (e == 0));
  endtask

  task automatic check_hilo(input string tag);
    bus.AluCtrl = 4'b1100;
    #1;
    check({tag, "_mfhi"}, bus.AluResult, m_hi);
    bus.AluCtrl = 4'b1101;
    #1;
    check({tag, "_mflo"}, bus.AluResult, m_lo);
  endtask

  // Launch c(a,b), wait for Done; at cycle 'interfere' (if nonzero) pulse Start with MULTU.
  // Returns inside the DONE cycle.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int interfere);
    logic [W-1:0] eh, el;
    int cyc, busy_bad, exp_lat;
    bit dz;
    ref_mdu(c, a, b, eh, el);
    dz = (c[3:1] == 3'b101) && (b == 0);
    exp_lat = dz ? 1 : W + 1;
    bus.Start   = 1'b1;
    bus.AluCtrl = c;
    bus.AluOp1  = a;
    bus.AluOp2  = b;
    tick();
    bus.Start   = 1'b0;
    bus.AluOp1  = $urandom;
    bus.AluOp2  = $urandom;
    bus.AluCtrl = 4'b1100;
    cyc = 1;
    busy_bad = 0;
    if (!dz) begin
      #1;
      check({tag, "_hi_while_busy"}, bus.AluResult, m_hi);
    end
    while (bus.Done !== 1'b1 && cyc <= 100) begin
      if (bus.Busy !== 1'b1) busy_bad++;
      if (cyc == interfere) begin
        bus.Start   = 1'b1;
        bus.AluCtrl = 4'b1001;
        bus.AluOp1  = $urandom;
        bus.AluOp2  = $urandom;
      end else begin
        bus.Start   = 1'b0;
        bus.AluCtrl = 4'b1100;
      end
      tick();
      cyc++;
    end
    bus.Start = 1'b0;
    check({tag, "_done_cycle"}, cyc, exp_lat);
    check({tag, "_busy_cycles"}, busy_bad, 0);
    check({tag, "_busy_in_done"}, bus.Busy, 1'b0);
    m_hi = eh;
    m_lo = el;
    check_hilo(tag);
  endtask

  initial begin
    bit done_seen;
    reset       = 1'b1;
    bus.Start   = 1'b0;
    bus.AluCtrl = 4'b0000;
    bus.AluOp1  = '0;
    bus.AluOp2  = '0;
    m_hi = '0;
    m_lo = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    check_hilo("rst");

    comb_check("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    comb_check("sub_zero", 4'b0110, 32'd5, 32'd5);
    comb_check("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'd1);
    comb_check("slt_pos",  4'b0111, 32'd1, 32'hFFFF_FFFF);
    comb_check("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
    comb_check("or",       4'b0001, 32'hF000_0001, 32'h0000_1000);
    comb_check("code_0011", 4'b0011, 32'h1234_5678, 32'h1);
    comb_check("code_1110", 4'b1110, 32'h1234_5678, 32'h1);
    comb_check("code_mult", 4'b1000, 32'h1234_5678, 32'h9);
    comb_check("code_divu", 4'b1011, 32'h1234_5678, 32'h9);

    run_op("mult", 4'b1000, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_hi_const", m_hi, 32'hFFFF_FFFF);
    tick();
    run_op("multu", 4'b1001, 32'hFFFF_FFFE, 32'd3, 0);
    check("multu_hi_const", m_hi, 32'h0000_0002);
    tick();

    // Start during RUN ignored, then a Start in the DONE cycle is accepted
    run_op("mult_ign", 4'b1000, 32'h8000_0001, 32'h7FFF_FFFF, 5);
    run_op("b2b_multu", 4'b1001, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
    tick();

`ifdef ALU_MDU_DIV_EN
    run_op("div_neg", 4'b1010, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_lo_const", m_lo, 32'hFFFF_FFFD);
    tick();
    run_op("divu_by0", 4'b1011, 32'd7, 32'd0, 0);
    tick();
    run_op("div_ovf", 4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    tick();
`else
    bus.Start   = 1'b1;
    bus.AluCtrl = 4'b1011;
    bus.AluOp1  = 32'd8;
    bus.AluOp2  = 32'd2;
    tick();
    bus.Start = 1'b0;
    check("nodiv_busy", bus.Busy, 1'b0);
    check("nodiv_done", bus.Done, 1'b0);
    tick();
    check("nodiv_done2", bus.Done, 1'b0);
    check_hilo("nodiv");
`endif

    // Start with a non-multi-cycle code does nothing
    bus.Start   = 1'b1;
    bus.AluCtrl = 4'b0010;
    tick();
    bus.Start = 1'b0;
    check("start_add_busy", bus.Busy, 1'b0);
    check("start_add_done", bus.Done, 1'b0);

    // Reset at RUN cycle 10 aborts without a Done pulse
    bus.Start   = 1'b1;
    bus.AluCtrl = 4'b1000;
    bus.AluOp1  = 32'h1234_5678;
    bus.AluOp2  = 32'h0000_0777;
    tick();
    bus.Start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("abort_busy", bus.Busy, 1'b0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done === 1'b1) done_seen = 1'b1;
      tick();
    end
    check("abort_no_done", done_seen, 1'b0);
    check_hilo("abort");

    // Reset wins over Start in the same cycle
    reset       = 1'b1;
    bus.Start   = 1'b1;
    bus.AluCtrl = 4'b1001;
    tick();
    reset     = 1'b0;
    bus.Start = 1'b0;
    check("rst_prio_busy", bus.Busy, 1'b0);
    tick();
    check("rst_prio_busy2", bus.Busy, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      comb_check($sformatf("rcomb%0d_c%0h", i, c), c, $urandom, $urandom);
    end

    for (int i = 0; i < 16; i++) begin
      logic [3:0] c;
      logic [W-1:0] a, b;
      c = 4'b1000 | 4'($urandom_range(0, NMDU - 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = '1; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rmdu%0d_c%0h", i, c), c, a, b, 0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
